reg_timeout_guard: RTL and testbench
====================================

// Module: reg_timeout_guard
// PURPOSE
//   Sits between a register-interface master and a single downstream slave (or demux port).
//   Forwards every request unchanged and tracks how long it stays outstanding.
//   If the slave does not assert ready within TIMEOUT cycles, the block withdraws the request
//   and answers the master itself: error=1, rdata=ERR_VAL, the same answer the error slave gives.
//   A hung or unmapped slave therefore cannot stall the bus.
// PARAMETERS
//   DW       32                    data width of rdata/wdata
//   TIMEOUT  256                   max cycles a request may stay outstanding (>=1, elaboration assert)
//   ERR_VAL  32'hBADCAB1E          rdata returned on a timeout response
//   CNT_W    $clog2(TIMEOUT+1)     cycle counter width (derived, do not override)
//   req_t    logic                 register-interface request struct (addr, write, wdata, wstrb, valid)
//   rsp_t    logic                 register-interface response struct (rdata, error, ready)
// PORTS
//   clk_i        in   1      clock
//   rst_ni       in   1      reset, synchronous, active-low
//   req_i        in   req_t  request from master
//   rsp_o        out  rsp_t  response to master
//   req_o        out  req_t  request to downstream slave
//   rsp_i        in   rsp_t  response from downstream slave
//   clr_i        in   1      clears timed_out_o and err_cnt_o
//   timeout_o    out  1      one-cycle pulse in the cycle the error response is given
//   timed_out_o  out  1      sticky: at least one timeout since reset/clear
//   err_cnt_o    out  16     saturating count of timeouts
// BEHAVIOUR
//   Handshake: a transfer completes in the cycle where valid && ready.
//     The master holds req stable until then.
//   States: IDLE, WAIT, ERR. Counter cnt is CNT_W bits wide.
//   IDLE (cnt=0): req_o=req_i, rsp_o=rsp_i (combinational pass-through).
//     valid & rsp_i.ready  -> transfer completes, stay in IDLE.
//     valid & !ready       -> go to ERR if TIMEOUT==1, else go to WAIT with cnt=1.
//   WAIT: pass-through as in IDLE.
//     rsp_i.ready -> go to IDLE, cnt=0.
//     !ready & cnt==TIMEOUT-1 -> go to ERR.
//     Otherwise cnt++.
//   ERR (exactly one cycle): the block answers the master itself.
//     req_o.valid=0; all other req_o fields = req_i.
//     rsp_o.ready=1, rsp_o.error=1, rsp_o.rdata=ERR_VAL.
//     timeout_o=1, timed_out_o<=1, err_cnt_o<=err_cnt_o+1 (saturating at 16'hFFFF).
//     rsp_i is ignored. Next state is IDLE.
//   Latency: pass-through adds 0 cycles.
//     With the request first valid at cycle 0, the slave may complete it at cycles 0..TIMEOUT-1.
//     The error response is given at cycle TIMEOUT.
//   Priority: rsp_i.ready in the cycle where cnt==TIMEOUT-1 wins; no timeout, normal completion.
//   Master drops valid while in WAIT (protocol violation): go to IDLE, cnt=0, no error response.
//   Back-to-back requests: after any completion, the next request is handled from IDLE with cnt=0.
//   clr_i together with a timeout in the same cycle: the set wins.
//     timed_out_o=1 and err_cnt_o=1 afterwards.
//   Reset (rst_ni low at a clock edge, also mid-transaction):
//     state=IDLE, cnt=0, timed_out_o=0, err_cnt_o=0.
//   While rst_ni is low: req_o.valid=0, rsp_o.ready=0, rsp_o.error=0, timeout_o=0.
//   An outstanding request is dropped silently when reset is applied.
// TESTING
//   Timing in all tests: TIMEOUT=4, first valid at cycle 0.
//   T1  write, slave ready at cycle 0 -> rsp_o.ready=1 at cycle 0, error=0, timeout_o never 1.
//   T2  read, slave ready at cycle 3 with rdata=32'h1234 -> rsp_o.rdata=32'h1234 at cycle 3,
//       error=0, err_cnt_o=0.
//   T3  read, slave never ready -> req_o.valid=1 in cycles 0..3 and 0 in cycle 4.
//       Cycle 4: rsp_o ready=1, error=1, rdata=32'hBADCAB1E, timeout_o=1.
//       Afterwards err_cnt_o=1, timed_out_o=1.
//   T4  two hung requests back to back -> error responses at cycles 4 and 9, err_cnt_o=2.
//       A third request completing at cycle 10 passes through with error=0.
//   T5  rst_ni low for one cycle at cycle 2 of a hung request -> IDLE, counters 0.
//       A new request valid from cycle 4 times out at cycle 8.
//   T6  clr_i=1 in the same cycle as a timeout -> timed_out_o=1, err_cnt_o=1.
//       clr_i again one cycle later -> both 0.
//       Preloaded err_cnt_o=16'hFFFF plus one more timeout -> stays 16'hFFFF.

Source files
------------

// File: rtl/reg_timeout_guard.sv
// Register-interface timeout guard. Forwards requests to one slave and answers the
// master with an error response itself if the slave stays not-ready for TIMEOUT cycles.
package reg_timeout_guard_pkg;
    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        valid;
    } reg_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } reg_rsp_t;
endpackage

module reg_timeout_guard #(
    parameter int unsigned   DW      = 32,
    parameter int unsigned   TIMEOUT = 256,
    parameter logic [DW-1:0] ERR_VAL = 32'hBADCAB1E,
    parameter int unsigned   CNT_W   = $clog2(TIMEOUT + 1),
    parameter type           req_t   = reg_timeout_guard_pkg::reg_req_t,
    parameter type           rsp_t   = reg_timeout_guard_pkg::reg_rsp_t
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  req_t        req_i,
    output rsp_t        rsp_o,
    output req_t        req_o,
    input  rsp_t        rsp_i,
    input  logic        clr_i,
    output logic        timeout_o,
    output logic        timed_out_o,
    output logic [15:0] err_cnt_o
);

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("reg_timeout_guard: TIMEOUT must be >= 1");
    end

    typedef enum logic [1:0] {IDLE, WAIT, ERR} state_e;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timed_out_q, timed_out_d;
    logic [15:0]      err_cnt_q, err_cnt_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        timed_out_d = timed_out_q;
        err_cnt_d   = err_cnt_q;
        if (clr_i) begin
            timed_out_d = 1'b0;
            err_cnt_d   = '0;
        end
        case (state_q)
            IDLE: begin
                if (req_i.valid && !rsp_i.ready) begin
                    state_d = (TIMEOUT == 1) ? ERR : WAIT;
                    cnt_d   = CNT_W'(1);
                end
            end
            WAIT: begin
                // A dropped valid is a master protocol violation: abandon silently.
                if (!req_i.valid || rsp_i.ready) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ERR;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ERR: begin
                state_d     = IDLE;
                cnt_d       = '0;
                timed_out_d = 1'b1;
                if (clr_i)
                    err_cnt_d = 16'd1;
                else if (err_cnt_q != 16'hFFFF)
                    err_cnt_d = err_cnt_q + 16'd1;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            timed_out_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            timed_out_q <= timed_out_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    // Zero-latency pass-through except in the single ERR cycle, where the guard answers.
    always_comb begin
        req_o     = req_i;
        rsp_o     = rsp_i;
        timeout_o = 1'b0;
        if (state_q == ERR) begin
            req_o.valid = 1'b0;
            rsp_o.ready = 1'b1;
            rsp_o.error = 1'b1;
            rsp_o.rdata = ERR_VAL;
            timeout_o   = 1'b1;
        end
        if (!rst_ni) begin
            req_o.valid = 1'b0;
            rsp_o.ready = 1'b0;
            rsp_o.error = 1'b0;
            timeout_o   = 1'b0;
        end
    end

    assign timed_out_o = timed_out_q;
    assign err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_reg_timeout_guard.sv
// Bench for reg_timeout_guard with TIMEOUT=4: scoreboard of expected responses plus
// per-scenario cycle checks of timing, pulses and counters.
module tb_reg_timeout_guard;
    import reg_timeout_guard_pkg::*;

    localparam logic [31:0] ERR_V = 32'hBADCAB1E;

    logic        clk = 1'b0;
    logic        rst_n, clr;
    reg_req_t    req_i, req_o;
    reg_rsp_t    rsp_i, rsp_o;
    logic        timeout, timed_out;
    logic [15:0] err_cnt;

    int          checks = 0;
    int          failures = 0;
    reg_rsp_t    exp_q[$];
    logic [15:0] exp_cnt;
    logic        exp_sticky;

    always #5 clk = ~clk;

    reg_timeout_guard #(.DW(32), .TIMEOUT(4)) dut (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req_i), .rsp_o(rsp_o),
        .req_o(req_o), .rsp_i(rsp_i), .clr_i(clr), .timeout_o(timeout),
        .timed_out_o(timed_out), .err_cnt_o(err_cnt)
    );

    function automatic reg_req_t mk_req(logic wr, logic [31:0] addr, logic [31:0] wdata);
        reg_req_t r;
        r.addr  = addr;
        r.write = wr;
        r.wdata = wdata;
        r.wstrb = wr ? 4'hF : 4'h0;
        r.valid = 1'b1;
        return r;
    endfunction

    function automatic reg_rsp_t mk_rsp(logic [31:0] rdata, logic err, logic rdy);
        reg_rsp_t r;
        r.rdata = rdata;
        r.error = err;
        r.ready = rdy;
        return r;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req_i = '0;
        rsp_i = '0;
        clr   = 1'b0;
    endtask

    // Every completed transfer seen by the master pops one expected response.
    always @(negedge clk) begin : scoreboard
        reg_rsp_t e;
        if (rst_n === 1'b1 && req_i.valid === 1'b1 && rsp_o.ready === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected_rsp actual rdata=%h error=%b, required no response",
                         rsp_o.rdata, rsp_o.error);
            end else begin
                e = exp_q.pop_front();
                if (rsp_o.rdata !== e.rdata || rsp_o.error !== e.error) begin
                    failures++;
                    $display("FAIL sb_rsp actual rdata=%h error=%b, required rdata=%h error=%b",
                             rsp_o.rdata, rsp_o.error, e.rdata, e.error);
                end
            end
        end
    end

    task automatic test_reset();
        rst_n = 1'b0;
        clr   = 1'b0;
        req_i = mk_req(1'b1, 32'h10, 32'hAA);
        rsp_i = mk_rsp(32'h77, 1'b1, 1'b1);
        next_cycle();
        next_cycle();
        @(negedge clk);
        checks++;
        if (req_o.valid !== 1'b0 || rsp_o.ready !== 1'b0 || rsp_o.error !== 1'b0 || timeout !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs actual valid=%b ready=%b error=%b timeout=%b, required 0 0 0 0",
                     req_o.valid, rsp_o.ready, rsp_o.error, timeout);
        end
        checks++;
        if (timed_out !== 1'b0 || err_cnt !== 16'd0) begin
            failures++;
            $display("FAIL reset_state actual timed_out=%b err_cnt=%0d, required 0 0", timed_out, err_cnt);
        end
        next_cycle();
        rst_n = 1'b1;
        idle();
        exp_cnt    = 16'd0;
        exp_sticky = 1'b0;
    endtask

    task automatic test_single_write();
        next_cycle();
        req_i = mk_req(1'b1, 32'h100, 32'hCAFE0001);
        rsp_i = mk_rsp(32'h0, 1'b0, 1'b1);
        exp_q.push_back(mk_rsp(32'h0, 1'b0, 1'b1));
        @(negedge clk);
        checks++;
        if (rsp_o.ready !== 1'b1 || rsp_o.error !== 1'b0) begin
            failures++;
            $display("FAIL t1_ready actual ready=%b error=%b, required 1 0", rsp_o.ready, rsp_o.error);
        end
        checks++;
        if (req_o !== req_i) begin
            failures++;
            $display("FAIL t1_req_pass actual %h, required %h", req_o, req_i);
        end
        checks++;
        if (timeout !== 1'b0) begin
            failures++;
            $display("FAIL t1_timeout actual %b, required 0", timeout);
        end
        next_cycle();
        idle();
        @(negedge clk);
    endtask

    task automatic test_slow_read();
        for (int c = 0; c <= 3; c++) begin
            next_cycle();
            if (c == 0) begin
                req_i = mk_req(1'b0, 32'h204, 32'h0);
                exp_q.push_back(mk_rsp(32'h1234, 1'b0, 1'b1));
            end
            rsp_i = mk_rsp((c == 3) ? 32'h1234 : 32'hDEAD, 1'b0, c == 3);
            @(negedge clk);
            checks++;
            if (rsp_o.ready !== (c == 3) || req_o.valid !== 1'b1 || timeout !== 1'b0) begin
                failures++;
                $display("FAIL t2_cycle%0d actual ready=%b valid=%b timeout=%b, required %b 1 0",
                         c, rsp_o.ready, req_o.valid, timeout, c == 3);
            end
        end
        next_cycle();
        idle();
        @(negedge clk);
        checks++;
        if (err_cnt !== exp_cnt || timed_out !== exp_sticky) begin
            failures++;
            $display("FAIL t2_counters actual err_cnt=%0d timed_out=%b, required %0d %b",
                     err_cnt, timed_out, exp_cnt, exp_sticky);
        end
    endtask

    task automatic test_timeout();
        for (int c = 0; c <= 4; c++) begin
            next_cycle();
            if (c == 0) begin
                req_i = mk_req(1'b0, 32'h300, 32'h0);
                exp_q.push_back(mk_rsp(ERR_V, 1'b1, 1'b1));
            end
            rsp_i = mk_rsp(32'h5A5A, 1'b0, 1'b0);
            @(negedge clk);
            checks++;
            if (req_o.valid !== (c < 4) || rsp_o.ready !== (c == 4) || timeout !== (c == 4)) begin
                failures++;
                $display("FAIL t3_cycle%0d actual valid=%b ready=%b timeout=%b, required %b %b %b",
                         c, req_o.valid, rsp_o.ready, timeout, c < 4, c == 4, c == 4);
            end
        end
        exp_cnt    = exp_cnt + 16'd1;
        exp_sticky = 1'b1;
        next_cycle();
        idle();
        @(negedge clk);
        checks++;
        if (err_cnt !== exp_cnt || timed_out !== exp_sticky || timeout !== 1'b0) begin
            failures++;
            $display("FAIL t3_counters actual err_cnt=%0d timed_out=%b timeout=%b, required %0d %b 0",
                     err_cnt, timed_out, timeout, exp_cnt, exp_sticky);
        end
    endtask

    task automatic test_back_to_back();
        next_cycle();
        idle();
        clr = 1'b1;
        next_cycle();
        clr = 1'b0;
        @(negedge clk);
        exp_cnt    = 16'd0;
        exp_sticky = 1'b0;
        checks++;
        if (err_cnt !== 16'd0 || timed_out !== 1'b0) begin
            failures++;
            $display("FAIL t4_clear actual err_cnt=%0d timed_out=%b, required 0 0", err_cnt, timed_out);
        end
        for (int c = 0; c <= 10; c++) begin
            next_cycle();
            if (c == 0 || c == 5) exp_q.push_back(mk_rsp(ERR_V, 1'b1, 1'b1));
            if (c == 10) exp_q.push_back(mk_rsp(32'h55, 1'b0, 1'b1));
            req_i = mk_req(1'b0, (c < 5) ? 32'h400 : (c < 10) ? 32'h404 : 32'h408, 32'h0);
            rsp_i = mk_rsp((c == 10) ? 32'h55 : 32'h5A5A, 1'b0, c == 10);
            @(negedge clk);
            checks++;
            if (timeout !== (c == 4 || c == 9) || rsp_o.ready !== (c == 4 || c == 9 || c == 10)
                || req_o.valid !== !(c == 4 || c == 9)) begin
                failures++;
                $display("FAIL t4_cycle%0d actual timeout=%b ready=%b valid=%b, required %b %b %b",
                         c, timeout, rsp_o.ready, req_o.valid, c == 4 || c == 9,
                         c == 4 || c == 9 || c == 10, !(c == 4 || c == 9));
            end
        end
        exp_cnt    = 16'd2;
        exp_sticky = 1'b1;
        next_cycle();
        idle();
        @(negedge clk);
        checks++;
        if (err_cnt !== exp_cnt || timed_out !== exp_sticky) begin
            failures++;
            $display("FAIL t4_counters actual err_cnt=%0d timed_out=%b, required %0d %b",
                     err_cnt, timed_out, exp_cnt, exp_sticky);
        end
    endtask

    task automatic test_valid_drop();
        for (int c = 0; c <= 12; c++) begin
            next_cycle();
            if (c == 8) exp_q.push_back(mk_rsp(ERR_V, 1'b1, 1'b1));
            req_i = mk_req(1'b1, (c < 2) ? 32'h500 : 32'h504, 32'h77);
            req_i.valid = (c < 2) || (c >= 8);
            rsp_i = mk_rsp(32'h0, 1'b0, 1'b0);
            @(negedge clk);
            checks++;
            if (timeout !== (c == 12) || rsp_o.ready !== (c == 12)) begin
                failures++;
                $display("FAIL drop_cycle%0d actual timeout=%b ready=%b, required %b %b",
                         c, timeout, rsp_o.ready, c == 12, c == 12);
            end
        end
        exp_cnt = exp_cnt + 16'd1;
        next_cycle();
        idle();
        @(negedge clk);
        checks++;
        if (err_cnt !== exp_cnt) begin
            failures++;
            $display("FAIL drop_counters actual err_cnt=%0d, required %0d", err_cnt, exp_cnt);
        end
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c <= 8; c++) begin
            next_cycle();
            if (c == 4) exp_q.push_back(mk_rsp(ERR_V, 1'b1, 1'b1));
            rst_n = (c != 2);
            req_i = mk_req(1'b0, (c <= 2) ? 32'h600 : 32'h604, 32'h0);
            req_i.valid = (c <= 2) || (c >= 4);
            rsp_i = mk_rsp(32'h0, 1'b1, 1'b0);
            @(negedge clk);
            if (c == 2) begin
                checks++;
                if (req_o.valid !== 1'b0 || rsp_o.ready !== 1'b0 || rsp_o.error !== 1'b0) begin
                    failures++;
                    $display("FAIL t5_in_reset actual valid=%b ready=%b error=%b, required 0 0 0",
                             req_o.valid, rsp_o.ready, rsp_o.error);
                end
            end
            if (c == 3) begin
                checks++;
                if (err_cnt !== 16'd0 || timed_out !== 1'b0) begin
                    failures++;
                    $display("FAIL t5_after_reset actual err_cnt=%0d timed_out=%b, required 0 0",
                             err_cnt, timed_out);
                end
            end
            checks++;
            if (timeout !== (c == 8)) begin
                failures++;
                $display("FAIL t5_timeout_c%0d actual %b, required %b", c, timeout, c == 8);
            end
        end
        exp_cnt    = 16'd1;
        exp_sticky = 1'b1;
        next_cycle();
        idle();
        @(negedge clk);
        checks++;
        if (err_cnt !== exp_cnt || timed_out !== exp_sticky) begin
            failures++;
            $display("FAIL t5_counters actual err_cnt=%0d timed_out=%b, required %0d %b",
                     err_cnt, timed_out, exp_cnt, exp_sticky);
        end
    endtask

    task automatic test_clear();
        for (int c = 0; c <= 6; c++) begin
            next_cycle();
            if (c == 0) exp_q.push_back(mk_rsp(ERR_V, 1'b1, 1'b1));
            req_i = mk_req(1'b1, 32'h700, 32'h1);
            req_i.valid = (c <= 4);
            rsp_i = mk_rsp(32'h0, 1'b0, 1'b0);
            clr   = (c == 4) || (c == 5);
            @(negedge clk);
            if (c == 5) begin
                checks++;
                if (timed_out !== 1'b1 || err_cnt !== 16'd1) begin
                    failures++;
                    $display("FAIL t6_set_wins actual timed_out=%b err_cnt=%0d, required 1 1",
                             timed_out, err_cnt);
                end
            end
            if (c == 6) begin
                checks++;
                if (timed_out !== 1'b0 || err_cnt !== 16'd0) begin
                    failures++;
                    $display("FAIL t6_clear actual timed_out=%b err_cnt=%0d, required 0 0",
                             timed_out, err_cnt);
                end
            end
        end
        next_cycle();
        idle();
        @(negedge clk);
    endtask

    task automatic test_saturate();
        next_cycle();
        idle();
        dut.err_cnt_q = 16'hFFFE;
        for (int c = 0; c <= 10; c++) begin
            next_cycle();
            if (c == 0 || c == 5) exp_q.push_back(mk_rsp(ERR_V, 1'b1, 1'b1));
            req_i = mk_req(1'b0, 32'h800, 32'h0);
            req_i.valid = (c < 10);
            rsp_i = mk_rsp(32'h0, 1'b0, 1'b0);
            @(negedge clk);
            if (c == 5 || c == 10) begin
                checks++;
                if (err_cnt !== 16'hFFFF) begin
                    failures++;
                    $display("FAIL sat_c%0d actual err_cnt=%h, required ffff", c, err_cnt);
                end
            end
        end
        next_cycle();
        idle();
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL sb_leftover actual %0d pending responses, required 0", exp_q.size());
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_single_write();
        test_slow_read();
        test_timeout();
        test_back_to_back();
        test_valid_drop();
        test_reset_mid();
        test_clear();
        test_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
